// File: rtl/shifter_pkg.sv
// Op codes and shared types for the pipelined barrel shifter.
// Optional flags (out_carry/out_zero) are built only with BSHIFT_FLAGS_EN.
package shifter_pkg;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t OP_SLL = 3'b000;
  localparam shift_op_t OP_SRL = 3'b001;
  localparam shift_op_t OP_SRA = 3'b010;
  localparam shift_op_t OP_ROL = 3'b011;
  localparam shift_op_t OP_ROR = 3'b100;

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One combinational mux level of the barrel shifter: shifts by SHIFT when en is set.
// The carry ports exist only when BSHIFT_FLAGS_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  shift_op_t        op,
  input  logic             en,
`ifdef BSHIFT_FLAGS_EN
  input  logic             carry_in,
  output logic             carry_out,
`endif
  output logic [WIDTH-1:0] data_out
);

  // Shifted or rotated word for this level; unknown op codes pass through.
  always_comb begin
    data_out = data_in;
    if (en) begin
      case (op)
        OP_SLL:  data_out = data_in << SHIFT;
        OP_SRL:  data_out = data_in >> SHIFT;
        OP_SRA:  data_out = $signed(data_in) >>> SHIFT;
        OP_ROL:  data_out = {data_in[WIDTH-SHIFT-1:0], data_in[WIDTH-1:WIDTH-SHIFT]};
        OP_ROR:  data_out = {data_in[SHIFT-1:0], data_in[WIDTH-1:SHIFT]};
        default: data_out = data_in;
      endcase
    end else begin
      data_out = data_in;
    end
  end

`ifdef BSHIFT_FLAGS_EN
  // Bit leaving the word at this level; the highest shifting level wins overall.
  always_comb begin
    carry_out = carry_in;
    if (en) begin
      case (op)
        OP_SLL:  carry_out = data_in[WIDTH-SHIFT];
        OP_SRL:  carry_out = data_in[SHIFT-1];
        OP_SRA:  carry_out = data_in[SHIFT-1];
        OP_ROL:  carry_out = data_in[WIDTH-SHIFT];
        OP_ROR:  carry_out = data_in[SHIFT-1];
        default: carry_out = carry_in;
      endcase
    end else begin
      carry_out = carry_in;
    end
  end
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator, one registered mux level per amount bit (LSB first),
// valid/ready on both sides with a global stall. Flags built only with BSHIFT_FLAGS_EN.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  logic             advance_s;
  logic [WIDTH-1:0] data_r [AMT_W];
  logic [AMT_W-1:0] valid_r;
  shift_op_t        op_r   [AMT_W-1];
  logic [AMT_W-1:0] amt_r  [AMT_W-1];

  logic [WIDTH-1:0] stage_in_s  [AMT_W];
  logic [WIDTH-1:0] stage_out_s [AMT_W];
  shift_op_t        stage_op_s  [AMT_W];
  logic [AMT_W-1:0] stage_amt_s [AMT_W];
  logic [AMT_W-1:0] stage_valid_s;

`ifdef BSHIFT_FLAGS_EN
  logic [AMT_W-1:0] carry_r;
  logic [AMT_W-1:0] carry_in_s;
  logic [AMT_W-1:0] carry_out_s;
  logic             zero_r;
`endif

  // The output register is the only place a stall can originate.
  assign advance_s = !valid_r[AMT_W-1] || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < AMT_W; k++) begin : gen_stage
    if (k == 0) begin : gen_head
      assign stage_in_s[k]    = in_data;
      assign stage_op_s[k]    = in_op;
      assign stage_amt_s[k]   = in_amt;
      assign stage_valid_s[k] = in_valid;
`ifdef BSHIFT_FLAGS_EN
      assign carry_in_s[k]    = 1'b0;
`endif
    end else begin : gen_link
      assign stage_in_s[k]    = data_r[k-1];
      assign stage_op_s[k]    = op_r[k-1];
      assign stage_amt_s[k]   = amt_r[k-1];
      assign stage_valid_s[k] = valid_r[k-1];
`ifdef BSHIFT_FLAGS_EN
      assign carry_in_s[k]    = carry_r[k-1];
`endif
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (2 ** k)
    ) u_stage (
      .data_in   (stage_in_s[k]),
      .op        (stage_op_s[k]),
      .en        (stage_amt_s[k][k]),
`ifdef BSHIFT_FLAGS_EN
      .carry_in  (carry_in_s[k]),
      .carry_out (carry_out_s[k]),
`endif
      .data_out  (stage_out_s[k])
    );
  end

  // Stage registers: all advance together, or all hold while the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int k = 0; k < AMT_W; k++) begin
        data_r[k] <= '0;
      end
      for (int k = 0; k < AMT_W - 1; k++) begin
        op_r[k]  <= OP_SLL;
        amt_r[k] <= '0;
      end
    end else if (advance_s) begin
      valid_r <= stage_valid_s;
      for (int k = 0; k < AMT_W; k++) begin
        data_r[k] <= stage_out_s[k];
      end
      for (int k = 0; k < AMT_W - 1; k++) begin
        op_r[k]  <= stage_op_s[k];
        amt_r[k] <= stage_amt_s[k];
      end
    end
  end

  assign out_valid = valid_r[AMT_W-1];
  assign out_data  = data_r[AMT_W-1];

`ifdef BSHIFT_FLAGS_EN
  // Flag registers ride alongside the data and obey the same stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_r <= '0;
      zero_r  <= 1'b0;
    end else if (advance_s) begin
      carry_r <= carry_out_s;
      zero_r  <= (stage_out_s[AMT_W-1] == '0);
    end
  end

  assign out_carry = carry_r[AMT_W-1];
  assign out_zero  = zero_r;
`else
  assign out_carry = 1'b0;
  assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=16): directed table, latency,
// stall, mid-flight reset and randomized traffic against a reference model.
module tb_pipelined_barrel_shifter;

  localparam int W     = 16;
  localparam int AMT_W = 4;
`ifdef BSHIFT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] data;
    logic [3:0]   amt;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [AMT_W-1:0] in_amt = '0;
  logic [2:0]       in_op = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_data;
  logic             out_carry;
  logic             out_zero;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_out_cyc = -1;
  bit   contig_en = 1'b0;
  bit   stall_mode = 1'b0;
  bit   held_valid = 1'b0;
  bit   accepted = 1'b0;
  logic [W-1:0] held_data = '0;
  exp_t pending;
  exp_t exp_q[$];
  vec_t tbl[15];

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the whole word, doubled word for rotates.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] d, input int a);
    exp_t r;
    logic [2*W-1:0] dbl;
    dbl = {d, d};
    r.carry = 1'b0;
    case (op)
      3'd0: begin r.data = d << a; if (a > 0) r.carry = d[W-a]; end
      3'd1: begin r.data = d >> a; if (a > 0) r.carry = d[a-1]; end
      3'd2: begin
        r.data = d >> a;
        if (d[W-1]) r.data = r.data | ~(16'hFFFF >> a);
        if (a > 0) r.carry = d[a-1];
      end
      3'd3: begin dbl = dbl << a; r.data = dbl[2*W-1:W]; if (a > 0) r.carry = r.data[0]; end
      3'd4: begin dbl = dbl >> a; r.data = dbl[W-1:0]; if (a > 0) r.carry = r.data[W-1]; end
      default: r.data = d;
    endcase
    r.zero = (r.data == 16'h0000);
    if (!FLAGS) begin
      r.carry = 1'b0;
      r.zero  = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_out++;
    if (contig_en) begin
      if (last_out_cyc >= 0) check("contiguous_output", 16'(cyc - last_out_cyc), 16'd1);
      last_out_cyc = cyc;
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL spurious_output: got data=%h with no beat outstanding", out_data);
    end else begin
      e = exp_q.pop_front();
      if (out_data !== e.data || out_carry !== e.carry || out_zero !== e.zero) begin
        n_err++;
        $display("FAIL beat_%0d: got data=%h carry=%b zero=%b, expected data=%h carry=%b zero=%b",
                 n_out, out_data, out_carry, out_zero, e.data, e.carry, e.zero);
      end
    end
  endtask

  // One cycle: sample just before the rising edge, then move to the next falling edge.
  task automatic tick();
    #4;
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(pending);
    if (out_valid && out_ready) check_out();
    if (stall_mode && !out_ready && out_valid) begin
      check("in_ready_in_stall", {15'd0, in_ready}, 16'd0);
      if (held_valid) check("held_out_data", out_data, held_data);
      held_data  = out_data;
      held_valid = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_beat(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] a);
    in_op   = op;
    in_data = d;
    in_amt  = a;
    pending = model(op, d, int'(a));
  endtask

  task automatic rand_beat();
    logic [W-1:0] d;
    logic [3:0]   a;
    case ($urandom % 8)
      0:       a = 4'd0;
      1:       a = 4'd15;
      default: a = 4'($urandom_range(0, 15));
    endcase
    case ($urandom % 10)
      0:       d = 16'h0000;
      1:       d = 16'h8000;
      2:       d = 16'hFFFF;
      default: d = 16'($urandom);
    endcase
    set_beat(3'($urandom_range(0, 7)), d, a);
  endtask

  // Send one beat into an idle pipe and count rising edges until out_valid.
  task automatic latency_beat(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] a,
                              input logic [W-1:0] res, input logic c);
    int n;
    n = 0;
    set_beat(op, d, a);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    check("latency", 16'(n), 16'(AMT_W));
    check("latency_data", out_data, res);
    check("latency_carry", {15'd0, out_carry}, {15'd0, c & FLAGS});
    check("latency_zero", {15'd0, out_zero}, {15'd0, (res == 16'h0000) & FLAGS});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int sent;
    tbl[0]  = '{3'b000, 16'h8001, 4'd1,  16'h0002, 1'b1, 1'b0};
    tbl[1]  = '{3'b010, 16'hF000, 4'd4,  16'hFF00, 1'b0, 1'b0};
    tbl[2]  = '{3'b001, 16'hF000, 4'd4,  16'h0F00, 1'b0, 1'b0};
    tbl[3]  = '{3'b011, 16'h1234, 4'd4,  16'h2341, 1'b1, 1'b0};
    tbl[4]  = '{3'b100, 16'h1234, 4'd4,  16'h4123, 1'b0, 1'b0};
    tbl[5]  = '{3'b111, 16'hABCD, 4'd7,  16'hABCD, 1'b0, 1'b0};
    tbl[6]  = '{3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0};
    tbl[7]  = '{3'b000, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0};
    tbl[8]  = '{3'b001, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1};
    tbl[10] = '{3'b011, 16'h8001, 4'd0,  16'h8001, 1'b0, 1'b0};
    tbl[11] = '{3'b001, 16'h0000, 4'd3,  16'h0000, 1'b0, 1'b1};
    tbl[12] = '{3'b100, 16'h0001, 4'd1,  16'h8000, 1'b1, 1'b0};
    tbl[13] = '{3'b001, 16'h000F, 4'd4,  16'h0000, 1'b1, 1'b1};
    tbl[14] = '{3'b101, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_flags", {14'd0, out_carry, out_zero}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    reset_n = 1'b1;
    @(negedge clk);

    latency_beat(3'b000, 16'h8001, 4'd1, 16'h0002, 1'b1);

    // Directed table, streamed back-to-back.
    contig_en    = 1'b1;
    last_out_cyc = -1;
    out_ready    = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_op    = tbl[i].op;
      in_data  = tbl[i].data;
      in_amt   = tbl[i].amt;
      pending.data  = tbl[i].res;
      pending.carry = tbl[i].carry & FLAGS;
      pending.zero  = tbl[i].zero & FLAGS;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    contig_en = 1'b0;
    check("table_drained", 16'(exp_q.size()), 16'd0);

    // Eight beats with a three-cycle output stall mid-stream.
    n_out      = 0;
    sent       = 0;
    stall_mode = 1'b1;
    for (int i = 0; i < 60 && (sent < 8 || exp_q.size() > 0); i++) begin
      out_ready = !(i >= 6 && i < 9);
      in_valid  = (sent < 8);
      if (in_valid && !accepted && i > 0) begin
        // keep the refused beat on the bus
      end else if (in_valid) begin
        rand_beat();
      end
      tick();
      if (accepted) sent++;
    end
    stall_mode = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    check("stall_delivered", 16'(n_out), 16'd8);
    check("stall_drained", 16'(exp_q.size()), 16'd0);

    // Reset with beats in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    check("pre_reset_out_valid", {15'd0, out_valid}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_out_data", out_data, 16'h0000);
    exp_q.delete();
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("no_stale_out_valid", {15'd0, out_valid}, 16'd0);
    latency_beat(3'b100, 16'h1234, 4'd4, 16'h4123, 1'b0);

    // Randomized traffic with random backpressure.
    sent = 0;
    in_valid = 1'b0;
    while (sent < 10000) begin
      if (!(in_valid && !accepted)) begin
        in_valid = ($urandom % 5) != 0;
        rand_beat();
      end
      out_ready = ($urandom % 5) != 0;
      tick();
      if (accepted) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    check("random_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
